// File: rtl/memory_phase.sv
// memory_phase: MEM stage of the rv32im_zbb pipeline.
// Latches the EX result and runs byte/half/word loads and stores over a
// req/ack data-memory port. Retires each op with a one-cycle valid_o pulse.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access that
// sees no ack for TIMEOUT_CYCLES cycles is aborted and retires with bus_err_o.
module memory_phase #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] store_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic [31:0] ex_mem_o,
    output logic [31:0] mem_wb_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Access size codes: none, byte, halfword, word
    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
            default:                             op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_HALF: is_misaligned = a[0];
            SZ_WORD: is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: byte_enables = 4'b0001 << a;
            SZ_HALF: byte_enables = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_enables = 4'b1111;
            default: byte_enables = 4'b0000;
        endcase
    endfunction

    // Replicate the store value across every lane so memory picks it via be
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: lane_wdata = {4{d[7:0]}};
            SZ_HALF: lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   load_extract = {{24{b[7]}}, b};
            OP_LBU:  load_extract = {24'd0, b};
            OP_LH:   load_extract = {{16{h[15]}}, h};
            OP_LHU:  load_extract = {16'd0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    logic [1:0] state_r;
    logic [3:0] op_r;
    logic       reg_write_lat_r;
    logic [1:0] in_size_s;
    logic       in_misalign_s;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] timeout_cnt_r;
`else
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = 8'(TIMEOUT_CYCLES);
`endif

    // New ops are taken in IDLE and in the RESP retire cycle, never mid-access
    assign ready_o = rst_n & (state_r != ST_ACCESS);

    // Classify the incoming op so the accept path can branch on it
    always_comb begin
        in_size_s     = op_size(mem_op_i);
        in_misalign_s = is_misaligned(in_size_s, alu_res_i[1:0]);
    end

    // Stage state machine, bus port and retire outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            op_r            <= 4'd0;
            reg_write_lat_r <= 1'b0;
            ex_mem_o        <= 32'd0;
            mem_wb_o        <= 32'd0;
            rd_o            <= 5'd0;
            reg_write_o     <= 1'b0;
            valid_o         <= 1'b0;
            misalign_o      <= 1'b0;
            bus_err_o       <= 1'b0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= 32'd0;
            dmem_be_o       <= 4'd0;
            dmem_wdata_o    <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            timeout_cnt_r   <= 8'd0;
`endif
        end else begin
            // Retire flags are single-cycle pulses
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    state_r <= ST_IDLE;
                    if (valid_i) begin
                        ex_mem_o        <= alu_res_i;
                        rd_o            <= rd_i;
                        op_r            <= mem_op_i;
                        reg_write_lat_r <= reg_write_i;
                        if (in_size_s == SZ_NONE) begin
                            valid_o     <= 1'b1;
                            mem_wb_o    <= alu_res_i;
                            reg_write_o <= reg_write_i;
                        end else if (in_misalign_s) begin
                            valid_o    <= 1'b1;
                            misalign_o <= 1'b1;
                            mem_wb_o   <= alu_res_i;
                        end else begin
                            state_r      <= ST_ACCESS;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= op_is_store(mem_op_i);
                            dmem_addr_o  <= {alu_res_i[31:2], 2'b00};
                            dmem_be_o    <= byte_enables(in_size_s, alu_res_i[1:0]);
                            dmem_wdata_o <= lane_wdata(in_size_s, store_data_i);
`ifdef MEM_TIMEOUT_EN
                            timeout_cnt_r <= 8'd0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        state_r    <= ST_RESP;
                        valid_o    <= 1'b1;
                        if (op_is_load(op_r)) begin
                            mem_wb_o    <= load_extract(op_r, ex_mem_o[1:0], dmem_rdata_i);
                            reg_write_o <= reg_write_lat_r;
                        end else begin
                            mem_wb_o <= ex_mem_o;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (timeout_cnt_r == 8'(TIMEOUT_CYCLES - 32'd1)) begin
                        // This cycle is the last one allowed without ack
                        dmem_req_o <= 1'b0;
                        state_r    <= ST_RESP;
                        valid_o    <= 1'b1;
                        bus_err_o  <= 1'b1;
                        mem_wb_o   <= ex_mem_o;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
`endif
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_phase.sv
// Self-checking bench for memory_phase: directed cases plus randomized ops
// checked against an arithmetic reference model of the MEM stage.
module tb_memory_phase;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic [31:0] ex_mem_o;
    logic [31:0] mem_wb_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    int n_assert = 0;
    int n_fail   = 0;

    memory_phase #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .alu_res_i(alu_res_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i),
        .rd_i(rd_i), .reg_write_i(reg_write_i), .ex_mem_o(ex_mem_o), .mem_wb_o(mem_wb_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .valid_o(valid_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input int op);
        case (op)
            1, 4, 6: m_size = 1;
            2, 5, 7: m_size = 2;
            3, 8:    m_size = 4;
            default: m_size = 0;
        endcase
    endfunction

    function automatic bit m_is_load(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic bit m_is_store(input int op);
        return (op >= 6) && (op <= 8);
    endfunction

    function automatic bit m_misaligned(input int op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        return (sz > 1) && ((addr % sz) != 0);
    endfunction

    function automatic logic [31:0] m_be(input int op, input logic [31:0] addr);
        case (m_size(op))
            1:       return 32'd1 << (addr % 4);
            2:       return ((addr % 4) >= 2) ? 32'd12 : 32'd3;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] sd);
        case (m_size(op))
            1:       return (sd & 32'hFF) * 32'h01010101;
            2:       return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (m_size(op) == 1) begin
            v = v & 32'hFF;
            if (op == 1 && v >= 32'd128) v = v - 32'd256;
        end else if (m_size(op) == 2) begin
            v = v & 32'hFFFF;
            if (op == 2 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // Drive one op, follow it through the stage and check every observable step
    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                          input int delay, input bit poke, input string tag);
        logic [31:0] exp_wb;
        logic        exp_rw;
        logic        exp_mis;
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = 4'(op); alu_res_i = addr; store_data_i = sd;
        rd_i = rd; reg_write_i = rw; dmem_ack_i = 1'b0;
        tick();
        valid_i = 1'b0;
        check({tag, "_exmem"}, ex_mem_o, addr);
        exp_mis = 1'b0;
        if (m_size(op) == 0) begin
            exp_wb = addr; exp_rw = rw;
        end else if (m_misaligned(op, addr)) begin
            exp_wb = addr; exp_rw = 1'b0; exp_mis = 1'b1;
        end else begin
            for (int c = 0; c <= delay; c++) begin
                check({tag, "_req"}, dmem_req_o, 32'd1);
                check({tag, "_ready_lo"}, ready_o, 32'd0);
                check({tag, "_addr"}, dmem_addr_o, addr & 32'hFFFFFFFC);
                check({tag, "_be"}, dmem_be_o, m_be(op, addr));
                check({tag, "_we"}, dmem_we_o, m_is_store(op) ? 32'd1 : 32'd0);
                if (m_is_store(op)) check({tag, "_wdata"}, dmem_wdata_o, m_wdata(op, sd));
                check({tag, "_exmem_hold"}, ex_mem_o, addr);
                @(negedge clk);
                if (c == delay) begin
                    dmem_ack_i = 1'b1; dmem_rdata_i = rdata; valid_i = 1'b0;
                end else begin
                    dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
                    if (poke) begin
                        valid_i = 1'b1; mem_op_i = 4'd0; alu_res_i = 32'hDEADBEEF;
                    end
                end
                tick();
                dmem_ack_i = 1'b0; valid_i = 1'b0;
            end
            exp_wb = m_is_load(op) ? m_load(op, addr, rdata) : addr;
            exp_rw = m_is_load(op) ? rw : 1'b0;
            check({tag, "_req_drop"}, dmem_req_o, 32'd0);
        end
        check({tag, "_valid"}, valid_o, 32'd1);
        check({tag, "_ready"}, ready_o, 32'd1);
        check({tag, "_wb"}, mem_wb_o, exp_wb);
        check({tag, "_rw"}, reg_write_o, exp_rw);
        check({tag, "_rd"}, rd_o, rd);
        check({tag, "_mis"}, misalign_o, exp_mis);
        check({tag, "_buserr"}, bus_err_o, 32'd0);
        if (m_size(op) == 0 || m_misaligned(op, addr)) check({tag, "_noreq"}, dmem_req_o, 32'd0);
        tick();
        check({tag, "_pulse"}, valid_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; alu_res_i = 32'd0; store_data_i = 32'd0;
        mem_op_i = 4'd0; rd_i = 5'd0; reg_write_i = 1'b0;
        dmem_rdata_i = 32'd0; dmem_ack_i = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", ready_o, 32'd0);
        check("rst_valid", valid_o, 32'd0);
        check("rst_req", dmem_req_o, 32'd0);
        check("rst_wb", mem_wb_o, 32'd0);
        check("rst_exmem", ex_mem_o, 32'd0);
        check("rst_rd", rd_o, 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_be", dmem_be_o, 32'd0);
        check("rst_wdata", dmem_wdata_o, 32'd0);
        check("rst_flags", {reg_write_o, misalign_o, bus_err_o, dmem_we_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        check("rst_release_ready", ready_o, 32'd1);

        // Directed cases
        run_op(0, 32'h12345678, 32'd0, 5'd5, 1'b1, 32'd0, 0, 1'b0, "pass");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i = 1'b1; mem_op_i = 4'd0; alu_res_i = 32'hA0000000 + i;
            rd_i = 5'(i + 1); reg_write_i = 1'b1;
            tick();
            check("b2b_valid", valid_o, 32'd1);
            check("b2b_wb", mem_wb_o, 32'hA0000000 + i);
            check("b2b_rd", rd_o, i + 1);
            check("b2b_ready", ready_o, 32'd1);
        end
        valid_i = 1'b0;
        run_op(1, 32'h00001003, 32'd0, 5'd7, 1'b1, 32'h80FF1234, 0, 1'b0, "lb");
        run_op(5, 32'h00001002, 32'd0, 5'd8, 1'b1, 32'h80010000, 0, 1'b0, "lhu");
        run_op(6, 32'h00002001, 32'h000000AB, 5'd9, 1'b1, 32'd0, 0, 1'b0, "sb");
        run_op(7, 32'h00002002, 32'h00001234, 5'd10, 1'b1, 32'd0, 1, 1'b0, "sh");
        run_op(3, 32'h00003002, 32'd0, 5'd11, 1'b1, 32'd0, 0, 1'b0, "lw_mis");
        run_op(3, 32'h00004000, 32'd0, 5'd12, 1'b1, 32'hCAFEF00D, 3, 1'b1, "lw_delay");

        // Ack while idle does nothing
        @(negedge clk); dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        check("idle_ack_valid", valid_o, 32'd0);
        check("idle_ack_req", dmem_req_o, 32'd0);

        // Reset during the second ACCESS cycle
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = 4'd3; alu_res_i = 32'h00005000; rd_i = 5'd3; reg_write_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("rstacc_req1", dmem_req_o, 32'd1);
        tick();
        check("rstacc_req2", dmem_req_o, 32'd1);
        @(negedge clk); rst_n = 1'b0;
        tick();
        check("rstacc_req_drop", dmem_req_o, 32'd0);
        check("rstacc_valid", valid_o, 32'd0);
        check("rstacc_ready", ready_o, 32'd0);
        @(negedge clk); rst_n = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h11111111;
        tick();
        dmem_ack_i = 1'b0;
        check("late_ack_valid", valid_o, 32'd0);
        check("late_ack_req", dmem_req_o, 32'd0);
        check("late_ack_wb", mem_wb_o, 32'd0);
        tick();
        check("late_ack_valid2", valid_o, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: request held for TIMEOUT_CYCLES cycles, then bus error retire
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = 4'd1; alu_res_i = 32'h00006001; rd_i = 5'd4; reg_write_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("tmo_req", dmem_req_o, 32'd1);
            check("tmo_novalid", valid_o, 32'd0);
            tick();
        end
        check("tmo_req_drop", dmem_req_o, 32'd0);
        check("tmo_valid", valid_o, 32'd1);
        check("tmo_buserr", bus_err_o, 32'd1);
        check("tmo_rw", reg_write_o, 32'd0);
        check("tmo_wb", mem_wb_o, 32'h00006001);
        tick();
        check("tmo_pulse", bus_err_o, 32'd0);
`endif

        // Randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            run_op(int'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
